mdr_handshake: RTL and testbench

- Parametrised memory data register for the downsampling processor datapath; successor to the fixed 8-bit, single-cycle MDR.
- Generalised data width.
- Adds a req/ack handshake to DRAM for both reads and writes, a timeout watchdog and a done pulse, so the control unit can sequence variable-latency memory.
- Sits between the shared bus and DRAM, alongside the MAR.

---
 rtl/mdr_handshake.sv | 188 ++++++++++++++++++
 tb/tb_mdr_handshake.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_handshake.sv
// Memory data register with req/ack DRAM handshake, wait watchdog and done pulse.
// Optional parity tracking and checking is compiled in with `define MDR_PARITY_EN.
module mdr_handshake #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            MDR_control,
    input  logic [DATA_WIDTH-1:0] bus_to_MDR,
    input  logic [DATA_WIDTH-1:0] DRAM_to_MDR,
    input  logic                  dram_ack,
`ifdef MDR_PARITY_EN
    input  logic                  DRAM_parity,
    output logic                  MDR_parity,
    output logic                  parity_err,
`endif
    output logic [DATA_WIDTH-1:0] MDR_to_bus,
    output logic [DATA_WIDTH-1:0] MDR_to_DRAM,
    output logic                  dram_rd_req,
    output logic                  dram_wr_req,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int CW_RAW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mdr;
    logic [DATA_WIDTH-1:0] w_mdr_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [CW-1:0]         w_cnt_inc;
    logic                  r_rd_req;
    logic                  w_rd_nxt;
    logic                  r_wr_req;
    logic                  w_wr_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_terr;
    logic                  w_terr_nxt;
    logic                  w_tmo;

`ifdef MDR_PARITY_EN
    logic                  r_par;
    logic                  r_perr;
    logic                  w_perr_nxt;
`endif

    // Counter saturates so a disabled watchdog never wraps.
    assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
    assign w_tmo     = TMO_EN && (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_mdr_nxt   = r_mdr;
        w_cnt_nxt   = r_cnt;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_terr_nxt  = r_terr;
`ifdef MDR_PARITY_EN
        w_perr_nxt  = r_perr;
`endif
        unique case (r_state)
            IDLE: begin
                unique case (MDR_control)
                    2'b10: begin
                        w_mdr_nxt  = bus_to_MDR;
                        w_done_nxt = 1'b1;
                        w_terr_nxt = 1'b0;
                    end
                    2'b01: begin
                        w_state_nxt = RD_WAIT;
                        w_rd_nxt    = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_terr_nxt  = 1'b0;
`ifdef MDR_PARITY_EN
                        w_perr_nxt  = 1'b0;
`endif
                    end
                    2'b11: begin
                        w_state_nxt = WR_WAIT;
                        w_wr_nxt    = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_terr_nxt  = 1'b0;
                    end
                    default: ;
                endcase
            end
            RD_WAIT: begin
                if (dram_ack) begin
                    w_state_nxt = IDLE;
                    w_mdr_nxt   = DRAM_to_MDR;
                    w_done_nxt  = 1'b1;
`ifdef MDR_PARITY_EN
                    if ((^DRAM_to_MDR) != DRAM_parity)
                        w_perr_nxt = 1'b1;
`endif
                end else if (w_tmo) begin
                    w_state_nxt = IDLE;
                    w_terr_nxt  = 1'b1;
                end else begin
                    w_rd_nxt   = 1'b1;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = w_cnt_inc;
                end
            end
            WR_WAIT: begin
                if (dram_ack) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_tmo) begin
                    w_state_nxt = IDLE;
                    w_terr_nxt  = 1'b1;
                end else begin
                    w_wr_nxt   = 1'b1;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = w_cnt_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mdr    <= '0;
            r_cnt    <= '0;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_terr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mdr    <= w_mdr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rd_req <= w_rd_nxt;
            r_wr_req <= w_wr_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_terr   <= w_terr_nxt;
        end
    end

`ifdef MDR_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_par  <= ^w_mdr_nxt;
            r_perr <= w_perr_nxt;
        end
    end

    assign MDR_parity = r_par;
    assign parity_err = r_perr;
`endif

    assign MDR_to_bus  = r_mdr;
    assign MDR_to_DRAM = r_mdr;
    assign dram_rd_req = r_rd_req;
    assign dram_wr_req = r_wr_req;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_mdr_handshake.sv
// Self-checking bench for mdr_handshake: directed vector table, async reset,
// and randomized traffic against a transaction-level model.
module tb_mdr_handshake;

    localparam int DW = 8;
    localparam int T  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    ctrl;
    logic [DW-1:0] bus;
    logic [DW-1:0] dram;
    logic          ack;
    logic          dpar;
    logic [DW-1:0] mdr_bus;
    logic [DW-1:0] mdr_dram;
    logic          rd_req;
    logic          wr_req;
    logic          busy;
    logic          done;
    logic          terr;
`ifdef MDR_PARITY_EN
    logic          mpar;
    logic          perr;
`endif

    int checks = 0;
    int errors = 0;

    mdr_handshake #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .MDR_control(ctrl),
        .bus_to_MDR (bus),
        .DRAM_to_MDR(dram),
        .dram_ack   (ack),
`ifdef MDR_PARITY_EN
        .DRAM_parity(dpar),
        .MDR_parity (mpar),
        .parity_err (perr),
`endif
        .MDR_to_bus (mdr_bus),
        .MDR_to_DRAM(mdr_dram),
        .dram_rd_req(rd_req),
        .dram_wr_req(wr_req),
        .busy       (busy),
        .done       (done),
        .timeout_err(terr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: op 0 = none, 1 = read, 2 = write;
    // m_age counts edges already spent waiting without ack.
    logic [DW-1:0] m_mdr;
    int            m_op;
    int            m_age;
    logic          m_done;
    logic          m_terr;
    logic          m_perr;

    task automatic model_reset();
        m_mdr  = '0;
        m_op   = 0;
        m_age  = 0;
        m_done = 1'b0;
        m_terr = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (m_op == 0) begin
            if (ctrl == 2'b10) begin
                m_mdr  = bus;
                m_done = 1'b1;
                m_terr = 1'b0;
            end else if (ctrl == 2'b01 || ctrl == 2'b11) begin
                m_op   = (ctrl == 2'b01) ? 1 : 2;
                m_age  = 0;
                m_terr = 1'b0;
                if (ctrl == 2'b01) m_perr = 1'b0;
            end
        end else if (ack) begin
            if (m_op == 1) begin
                m_mdr = dram;
                if ((^dram) != dpar) m_perr = 1'b1;
            end
            m_done = 1'b1;
            m_op   = 0;
        end else if (m_age + 1 == T) begin
            m_op   = 0;
            m_terr = 1'b1;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_model();
        chk("mdr_to_bus", 32'(mdr_bus), 32'(m_mdr));
        chk("mdr_to_dram", 32'(mdr_dram), 32'(m_mdr));
        chk("rd_req", 32'(rd_req), 32'(m_op == 1));
        chk("wr_req", 32'(wr_req), 32'(m_op == 2));
        chk("busy", 32'(busy), 32'(m_op != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("timeout_err", 32'(terr), 32'(m_terr));
        chk("req_exclusive", 32'(rd_req & wr_req), 32'd0);
`ifdef MDR_PARITY_EN
        chk("mdr_parity", 32'(mpar), 32'(^m_mdr));
        chk("parity_err", 32'(perr), 32'(m_perr));
`endif
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic [1:0]    c;
        logic [DW-1:0] b;
        logic [DW-1:0] d;
        logic          a;
        logic [DW-1:0] m;
        logic          rd;
        logic          wr;
        logic          dn;
        logic          te;
    } vec_t;

    function automatic vec_t v(input logic [1:0] c, input logic [DW-1:0] b,
                               input logic [DW-1:0] d, input logic a,
                               input logic [DW-1:0] m, input logic rd,
                               input logic wr, input logic dn, input logic te);
        vec_t r;
        r.c = c; r.b = b; r.d = d; r.a = a; r.m = m;
        r.rd = rd; r.wr = wr; r.dn = dn; r.te = te;
        return r;
    endfunction

    vec_t tv[29];

    initial begin
        // load, 3-cycle read, write with ignored bus loads, timeout,
        // ack-beats-timeout, minimum-latency read/write, ack ignored in idle
        tv[0]  = v(2'b10, 8'h3C, 8'h00, 1'b0, 8'h3C, 0, 0, 1, 0);
        tv[1]  = v(2'b00, 8'h00, 8'h00, 1'b0, 8'h3C, 0, 0, 0, 0);
        tv[2]  = v(2'b01, 8'h00, 8'h7E, 1'b0, 8'h3C, 1, 0, 0, 0);
        tv[3]  = v(2'b00, 8'h00, 8'h7E, 1'b0, 8'h3C, 1, 0, 0, 0);
        tv[4]  = v(2'b00, 8'h00, 8'h7E, 1'b0, 8'h3C, 1, 0, 0, 0);
        tv[5]  = v(2'b00, 8'h00, 8'h7E, 1'b1, 8'h7E, 0, 0, 1, 0);
        tv[6]  = v(2'b00, 8'h00, 8'h00, 1'b0, 8'h7E, 0, 0, 0, 0);
        tv[7]  = v(2'b10, 8'h11, 8'h00, 1'b0, 8'h11, 0, 0, 1, 0);
        tv[8]  = v(2'b11, 8'h00, 8'h00, 1'b0, 8'h11, 0, 1, 0, 0);
        tv[9]  = v(2'b10, 8'hFF, 8'h00, 1'b0, 8'h11, 0, 1, 0, 0);
        tv[10] = v(2'b10, 8'hFF, 8'h00, 1'b0, 8'h11, 0, 1, 0, 0);
        tv[11] = v(2'b00, 8'h00, 8'h00, 1'b1, 8'h11, 0, 0, 1, 0);
        tv[12] = v(2'b00, 8'h00, 8'h00, 1'b0, 8'h11, 0, 0, 0, 0);
        tv[13] = v(2'b01, 8'h00, 8'hAA, 1'b0, 8'h11, 1, 0, 0, 0);
        tv[14] = v(2'b00, 8'h00, 8'hAA, 1'b0, 8'h11, 1, 0, 0, 0);
        tv[15] = v(2'b00, 8'h00, 8'hAA, 1'b0, 8'h11, 1, 0, 0, 0);
        tv[16] = v(2'b00, 8'h00, 8'hAA, 1'b0, 8'h11, 1, 0, 0, 0);
        tv[17] = v(2'b00, 8'h00, 8'hAA, 1'b0, 8'h11, 0, 0, 0, 1);
        tv[18] = v(2'b00, 8'h00, 8'hAA, 1'b1, 8'h11, 0, 0, 0, 1);
        tv[19] = v(2'b10, 8'h5A, 8'h00, 1'b0, 8'h5A, 0, 0, 1, 0);
        tv[20] = v(2'b01, 8'h00, 8'hC3, 1'b0, 8'h5A, 1, 0, 0, 0);
        tv[21] = v(2'b00, 8'h00, 8'hC3, 1'b0, 8'h5A, 1, 0, 0, 0);
        tv[22] = v(2'b00, 8'h00, 8'hC3, 1'b0, 8'h5A, 1, 0, 0, 0);
        tv[23] = v(2'b00, 8'h00, 8'hC3, 1'b0, 8'h5A, 1, 0, 0, 0);
        tv[24] = v(2'b00, 8'h00, 8'hC3, 1'b1, 8'hC3, 0, 0, 1, 0);
        tv[25] = v(2'b01, 8'h00, 8'h99, 1'b1, 8'hC3, 1, 0, 0, 0);
        tv[26] = v(2'b00, 8'h00, 8'h99, 1'b1, 8'h99, 0, 0, 1, 0);
        tv[27] = v(2'b11, 8'h00, 8'h00, 1'b1, 8'h99, 0, 1, 0, 0);
        tv[28] = v(2'b00, 8'h00, 8'h00, 1'b1, 8'h99, 0, 0, 1, 0);

        reset = 1'b1;
        ctrl  = 2'b00;
        bus   = '0;
        dram  = '0;
        ack   = 1'b0;
        dpar  = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_model();
        @(negedge clock);
        reset = 1'b0;
        #1;

        foreach (tv[i]) begin
            ctrl = tv[i].c;
            bus  = tv[i].b;
            dram = tv[i].d;
            ack  = tv[i].a;
            dpar = ^tv[i].d;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_mdr", i), 32'(mdr_bus), 32'(tv[i].m));
            chk($sformatf("vec%0d_mdr_dram", i), 32'(mdr_dram), 32'(tv[i].m));
            chk($sformatf("vec%0d_rd_req", i), 32'(rd_req), 32'(tv[i].rd));
            chk($sformatf("vec%0d_wr_req", i), 32'(wr_req), 32'(tv[i].wr));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].rd | tv[i].wr));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(tv[i].dn));
            chk($sformatf("vec%0d_terr", i), 32'(terr), 32'(tv[i].te));
`ifdef MDR_PARITY_EN
            chk($sformatf("vec%0d_mpar", i), 32'(mpar), 32'(^tv[i].m));
            chk($sformatf("vec%0d_perr", i), 32'(perr), 32'd0);
`endif
        end

        // Async reset in the middle of a read, between clock edges
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        ctrl = 2'b10; bus = 8'hA5; ack = 1'b0; dpar = 1'b0;
        step();
        ctrl = 2'b01; dram = 8'h42;
        step();
        ctrl = 2'b00;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_mdr", 32'(mdr_bus), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_rd_req", 32'(rd_req), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ack = 1'b1;
        step();

`ifdef MDR_PARITY_EN
        ack = 1'b0; ctrl = 2'b01; dram = 8'h01; dpar = 1'b0;
        step();
        ctrl = 2'b00; ack = 1'b1;
        step();
        chk("par_err_set", 32'(perr), 32'd1);
        chk("par_mdr", 32'(mdr_bus), 32'h01);
        chk("par_bit", 32'(mpar), 32'd1);
`endif

        for (int n = 0; n < 3000; n++) begin
            ctrl = 2'($urandom_range(0, 3));
            bus  = DW'($urandom);
            dram = DW'($urandom);
            ack  = ($urandom_range(0, 9) < 3);
            dpar = (($urandom_range(0, 7) == 0)) ? ~(^dram) : ^dram;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
